// File: rtl/mc_dp_pkg.sv
// Shared types and encodings for the multi-cycle MIPS datapath with multiply unit.
package mc_dp_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_HI, WB_LO} memtoreg_e;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_JR} pcsrc_e;
  typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_IMM4} alusrcb_e;
  typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_DONE} mdu_state_e;

  // R-type view of the instruction register
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

endpackage

// File: rtl/mc_mdu.sv
// Iterative shift-add multiplier producing a 2*WIDTH product into HI/LO.
module mc_mdu
  import mc_dp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  mdu_state_e        state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [WIDTH-1:0]  mcand, mcand_n;
  logic [PW-1:0]     prod, prod_n;
  logic              neg, neg_n;
  logic              busy_n, done_n;
  logic [WIDTH:0]    step_sum;
  logic [PW-1:0]     result;

  // Low half of prod holds the remaining multiplier bits; high half accumulates.
  assign step_sum = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign result   = neg ? -prod : prod;

  always_comb begin
    state_n = state;
    count_n = count;
    mcand_n = mcand;
    prod_n  = prod;
    neg_n   = neg;
    case (state)
      MDU_IDLE: begin
        if (start) begin
          mcand_n = (sgn && a[WIDTH-1]) ? -a : a;
          prod_n  = {WIDTH'(0), ((sgn && b[WIDTH-1]) ? -b : b)};
          neg_n   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          count_n = CW'(WIDTH);
          state_n = MDU_RUN;
        end
      end
      MDU_RUN: begin
        if (count == '0) begin
          state_n = MDU_DONE;
        end else begin
          prod_n  = {step_sum, prod[WIDTH-1:1]};
          count_n = count - CW'(1);
        end
      end
      MDU_DONE: state_n = MDU_IDLE;
      default:  state_n = MDU_IDLE;
    endcase
    busy_n = (state_n != MDU_IDLE);
    done_n = (state_n == MDU_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MDU_IDLE;
      count <= '0;
      mcand <= '0;
      prod  <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      mcand <= mcand_n;
      prod  <= prod_n;
      neg   <= neg_n;
      busy  <= busy_n;
      done  <= done_n;
      // HI/LO commit at the end of DONE so a same-cycle read sees the old product
      if (state == MDU_DONE) begin
        {hi, lo} <= result;
      end
    end
  end

endmodule

// File: rtl/mc_datapath_mdu.sv
// Multi-cycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, register file, ALU, muxes and MDU.
module mc_datapath_mdu
  import mc_dp_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      NREGS    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcen,
  input  logic             iord,
  input  logic             irwrite,
  input  logic             regdst,
  input  logic [1:0]       memtoreg,
  input  logic             regwrite,
  input  logic             alusrca,
  input  logic [1:0]       alusrcb,
  input  logic [2:0]       alucontrol,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] readdata,
  input  logic             mdu_start,
  input  logic             mdu_signed,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             zero,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  output logic             mdu_busy,
  output logic             mdu_done
);

  localparam int unsigned RAW = $clog2(NREGS);

  logic [WIDTH-1:0]   pc, mdr, a, b, aluout;
  logic [INSTR_W-1:0] ir;
  instr_t             ins;
  logic [WIDTH-1:0]   pcnext, srca, srcb, aluresult;
  logic [WIDTH-1:0]   signimm, jtarget, wd3, rd1, rd2;
  logic [WIDTH-1:0]   hi, lo;
  logic [RAW-1:0]     ra1, ra2, wa;
  logic [WIDTH-1:0]   rf [NREGS];

  assign ins       = ir;
  assign op        = ins.op;
  assign funct     = ins.funct;
  assign adr       = iord ? aluout : pc;
  assign writedata = b;
  assign zero      = (aluresult == '0);
  assign signimm   = {{(WIDTH-16){ir[15]}}, ir[15:0]};
  assign jtarget   = {pc[WIDTH-1:28], ir[25:0], 2'b00};

  // Architectural and inter-cycle registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      if (pcen) begin
        pc <= pcnext;
      end
      if (irwrite) begin
        ir <= readdata[INSTR_W-1:0];
      end
      mdr    <= readdata;
      a      <= rd1;
      b      <= rd2;
      aluout <= aluresult;
    end
  end

  // Register file: combinational reads, register 0 hard-wired to zero
  assign ra1 = RAW'(ins.rs);
  assign ra2 = RAW'(ins.rt);
  assign wa  = regdst ? RAW'(ins.rd) : RAW'(ins.rt);
  assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf[ra2];

  always_ff @(posedge clk) begin
    if (regwrite && (wa != '0)) begin
      rf[wa] <= wd3;
    end
  end

  always_comb begin
    wd3 = aluout;
    case (memtoreg_e'(memtoreg))
      WB_ALU: wd3 = aluout;
      WB_MEM: wd3 = mdr;
      WB_HI:  wd3 = hi;
      WB_LO:  wd3 = lo;
      default: wd3 = aluout;
    endcase
  end

  assign srca = alusrca ? a : pc;

  always_comb begin
    srcb = b;
    case (alusrcb_e'(alusrcb))
      SRCB_B:    srcb = b;
      SRCB_FOUR: srcb = WIDTH'(4);
      SRCB_IMM:  srcb = signimm;
      SRCB_IMM4: srcb = {signimm[WIDTH-3:0], 2'b00};
      default:   srcb = b;
    endcase
  end

  always_comb begin
    aluresult = '0;
    case (alucontrol)
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_ADD: aluresult = srca + srcb;
      ALU_SUB: aluresult = srca - srcb;
      ALU_SLT: aluresult = WIDTH'($signed(srca) < $signed(srcb));
      default: aluresult = '0;
    endcase
  end

  always_comb begin
    pcnext = aluresult;
    case (pcsrc_e'(pcsrc))
      PC_ALU:    pcnext = aluresult;
      PC_ALUOUT: pcnext = aluout;
      PC_JUMP:   pcnext = jtarget;
      PC_JR:     pcnext = a;
      default:   pcnext = aluresult;
    endcase
  end

  mc_mdu #(.WIDTH(WIDTH)) u_mdu (
    .clk   (clk),
    .reset (reset),
    .start (mdu_start),
    .sgn   (mdu_signed),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (mdu_busy),
    .done  (mdu_done)
  );

endmodule

// File: tb/tb_mc_datapath_mdu.sv
// Self-checking bench for mc_datapath_mdu against a behavioural register/HI/LO/PC model.
module tb_mc_datapath_mdu;

  logic        clk, reset, pcen, iord, irwrite, regdst, regwrite, alusrca;
  logic [1:0]  memtoreg, alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic        mdu_start, mdu_signed;
  logic [5:0]  op, funct;
  logic        zero;
  logic [31:0] adr, writedata;
  logic        mdu_busy, mdu_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rf_m [32];
  logic [31:0] hi_m, lo_m;

  mc_datapath_mdu #(.WIDTH(32), .NREGS(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .pcen(pcen), .iord(iord), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc), .readdata(readdata),
    .mdu_start(mdu_start), .mdu_signed(mdu_signed), .op(op), .funct(funct),
    .zero(zero), .adr(adr), .writedata(writedata), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] x, input logic [31:0] y, input logic sgn);
    logic signed [63:0] sx, sy;
    if (sgn) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      3'b000: return x & y;
      3'b001: return x | y;
      3'b010: return x + y;
      3'b110: return x - y;
      3'b111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [31:0] ins);
    readdata = ins;
    irwrite  = 1'b1;
    tick();
    irwrite  = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    set_ir({6'd0, 5'd0, r, 16'd0});
    readdata = v;
    tick();
    memtoreg = 2'b01; regdst = 1'b0; regwrite = 1'b1;
    tick();
    regwrite = 1'b0; memtoreg = 2'b00;
    if (r != 5'd0) rf_m[r] = v;
  endtask

  task automatic wb_hilo(input logic [4:0] r, input logic [1:0] sel);
    set_ir({6'd0, 5'd0, r, 16'd0});
    memtoreg = sel; regdst = 1'b0; regwrite = 1'b1;
    tick();
    regwrite = 1'b0; memtoreg = 2'b00;
    if (r != 5'd0) rf_m[r] = (sel == 2'b10) ? hi_m : lo_m;
  endtask

  task automatic read_regs(input logic [4:0] rs, input logic [4:0] rt,
                           output logic [31:0] av, output logic [31:0] bv);
    set_ir({6'd0, rs, rt, 16'd0});
    tick();
    bv = writedata;
    alusrca = 1'b1; alusrcb = 2'b10; alucontrol = 3'b010; iord = 1'b1;
    tick();
    av = adr;
    alusrca = 1'b0; alusrcb = 2'b00; iord = 1'b0;
  endtask

  task automatic do_mul(input logic [31:0] x, input logic [31:0] y, input logic sgn);
    logic [31:0] old_hi, ra, rb;
    logic [63:0] p;
    int n;
    write_reg(5'd1, x);
    write_reg(5'd2, y);
    set_ir({6'd0, 5'd1, 5'd2, 16'd0});
    tick();
    mdu_start = 1'b1; mdu_signed = sgn;
    tick();
    mdu_start = 1'b0; mdu_signed = ~sgn;
    // Retarget A/B to other registers while the multiply runs
    readdata = {6'd0, 5'd5, 5'd6, 5'd7, 11'd0};
    irwrite  = 1'b1;
    n = 0;
    while (!mdu_done && n < 40) begin
      mdu_start = (n == 10);
      tick();
      irwrite = 1'b0;
      n++;
    end
    mdu_start = 1'b0;
    chk("mul_latency", 64'(n), 64'd33);
    chk("mul_busy_in_done", {63'd0, mdu_busy}, 64'd1);
    old_hi = hi_m;
    p = mul_ref(x, y, sgn);
    regdst = 1'b0; memtoreg = 2'b10; regwrite = 1'b1;
    tick();
    rf_m[6] = old_hi;
    hi_m = p[63:32];
    lo_m = p[31:0];
    chk("mul_done_pulse", {63'd0, mdu_done}, 64'd0);
    regdst = 1'b1;
    tick();
    rf_m[7] = hi_m;
    regwrite = 1'b0; regdst = 1'b0; memtoreg = 2'b00;
    chk("mul_idle", {63'd0, mdu_busy}, 64'd0);
    wb_hilo(5'd8, 2'b11);
    read_regs(5'd6, 5'd7, ra, rb);
    chk("mul_hi_old", {32'd0, ra}, {32'd0, rf_m[6]});
    chk("mul_hi_new", {32'd0, rb}, {32'd0, rf_m[7]});
    read_regs(5'd8, 5'd0, ra, rb);
    chk("mul_lo", {32'd0, ra}, {32'd0, rf_m[8]});
  endtask

  initial begin
    logic [31:0] ra, rb, x, y, exp_r;
    logic [2:0]  ops [6];
    int dones;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010;
    ops[3] = 3'b110; ops[4] = 3'b111; ops[5] = 3'b011;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    reset = 1'b0; pcen = 1'b0; iord = 1'b0; irwrite = 1'b0; regdst = 1'b0;
    regwrite = 1'b0; alusrca = 1'b0; memtoreg = 2'b00; alusrcb = 2'b00;
    alucontrol = 3'b000; pcsrc = 2'b00; readdata = 32'd0;
    mdu_start = 1'b0; mdu_signed = 1'b0;

    // Reset state
    tick();
    reset = 1'b1;
    chk("rst_adr", {32'd0, adr}, 64'h100);
    chk("rst_busy", {63'd0, mdu_busy}, 64'd0);
    chk("rst_done", {63'd0, mdu_done}, 64'd0);
    wb_hilo(5'd3, 2'b10);
    wb_hilo(5'd4, 2'b11);
    read_regs(5'd3, 5'd4, ra, rb);
    chk("rst_hi", {32'd0, ra}, {32'd0, hi_m});
    chk("rst_lo", {32'd0, rb}, {32'd0, lo_m});

    // Register 0 and write/read timing
    write_reg(5'd0, 32'd5);
    read_regs(5'd0, 5'd0, ra, rb);
    chk("r0_a", {32'd0, ra}, 64'd0);
    chk("r0_b", {32'd0, rb}, 64'd0);
    write_reg(5'd9, 32'h55);
    set_ir({6'd0, 5'd9, 5'd9, 16'd0});
    readdata = 32'h1234;
    tick();
    memtoreg = 2'b01; regwrite = 1'b1;
    tick();
    regwrite = 1'b0; memtoreg = 2'b00;
    chk("rf_same_cycle_old", {32'd0, writedata}, {32'd0, rf_m[9]});
    rf_m[9] = 32'h1234;
    tick();
    chk("rf_next_cycle_new", {32'd0, writedata}, {32'd0, rf_m[9]});

    // Multiplies: directed then random
    do_mul(32'hFFFFFFFD, 32'd7, 1'b1);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_mul(32'h80000000, 32'h80000000, 1'b1);
    for (int i = 0; i < 4; i++) do_mul($urandom, $urandom, 1'($urandom_range(0, 1)));

    // ALU operations with random operands (first pair equal)
    for (int it = 0; it < 3; it++) begin
      x = $urandom;
      y = (it == 0) ? x : $urandom;
      write_reg(5'd12, x);
      write_reg(5'd13, y);
      read_regs(5'd12, 5'd13, ra, rb);
      for (int k = 0; k < 6; k++) begin
        alusrca = 1'b1; alusrcb = 2'b00; alucontrol = ops[k]; iord = 1'b1;
        exp_r = alu_ref(ops[k], rf_m[12], rf_m[13]);
        #1;
        chk("alu_zero", {63'd0, zero}, {63'd0, (exp_r == 32'd0)});
        tick();
        chk("alu_result", {32'd0, adr}, {32'd0, exp_r});
      end
      alusrca = 1'b0; iord = 1'b0; alucontrol = 3'b000;
    end

    // Next-PC sources: jr, jump, PC+4, ALUOut
    write_reg(5'd10, 32'h40);
    set_ir({6'd0, 5'd10, 5'd0, 16'd0});
    tick();
    pcsrc = 2'b11; pcen = 1'b1;
    tick();
    pcen = 1'b0;
    chk("pc_jr", {32'd0, adr}, 64'h40);
    write_reg(5'd11, 32'h10000000);
    set_ir({6'd0, 5'd11, 5'd0, 16'd0});
    tick();
    pcen = 1'b1;
    tick();
    pcen = 1'b0;
    set_ir({6'd2, 26'h0000100});
    chk("op_field", {58'd0, op}, 64'd2);
    pcsrc = 2'b10; pcen = 1'b1;
    tick();
    pcen = 1'b0;
    chk("pc_jump", {32'd0, adr}, 64'h10000400);
    pcsrc = 2'b00; alusrca = 1'b0; alusrcb = 2'b01; alucontrol = 3'b010; pcen = 1'b1;
    tick();
    pcen = 1'b0;
    chk("pc_plus4", {32'd0, adr}, 64'h10000404);
    tick();
    pcsrc = 2'b01; pcen = 1'b1;
    tick();
    pcen = 1'b0; pcsrc = 2'b00; alusrcb = 2'b00;
    chk("pc_aluout", {32'd0, adr}, 64'h10000408);

    // Reset in the middle of a multiply
    write_reg(5'd1, 32'd1234);
    write_reg(5'd2, 32'd5678);
    set_ir({6'd0, 5'd1, 5'd2, 16'd0});
    tick();
    mdu_start = 1'b1; mdu_signed = 1'b0;
    tick();
    mdu_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_busy", {63'd0, mdu_busy}, 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    chk("abort_busy", {63'd0, mdu_busy}, 64'd0);
    chk("abort_pc", {32'd0, adr}, 64'h100);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mdu_done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    wb_hilo(5'd14, 2'b10);
    wb_hilo(5'd15, 2'b11);
    read_regs(5'd14, 5'd15, ra, rb);
    chk("abort_hi", {32'd0, ra}, {32'd0, hi_m});
    chk("abort_lo", {32'd0, rb}, {32'd0, lo_m});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
